// File: rtl/sudoku_pkg.sv
// Shared sudoku definitions: grid geometry, key command encodings and grid typedef.
package sudoku_pkg;

    localparam int unsigned GRID_DIM   = 9;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned POS_W      = 4;
    localparam int unsigned NUM_CELLS  = GRID_DIM * GRID_DIM;
    localparam int unsigned CELL_IDX_W = 7;

    typedef enum logic [3:0] {
        KEY_UP    = 4'd0,
        KEY_DOWN  = 4'd1,
        KEY_LEFT  = 4'd2,
        KEY_RIGHT = 4'd3,
        KEY_ENTER = 4'd4,
        KEY_ERASE = 4'd5,
        KEY_CLEAR = 4'd6
    } key_code_e;

    // Low two bits of the movement key codes map directly onto this.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [GRID_DIM-1:0][GRID_DIM-1:0][DIGIT_W-1:0] grid_t;

    function automatic logic is_digit(input digit_t v);
        return (v >= 4'd1) && (v <= 4'd9);
    endfunction

endpackage

// File: rtl/guess_grid_ctrl_if.sv
// Key command / result handshake between the keypad front end and guess_grid_ctrl.
interface guess_grid_ctrl_if;
    import sudoku_pkg::*;

    logic         key_valid;
    logic [3:0]   key_code;
    digit_t       user_value;
    logic         busy;
    logic         write_ack;
    logic         reject;

    modport master (
        output key_valid, key_code, user_value,
        input  busy, write_ack, reject
    );

    modport slave (
        input  key_valid, key_code, user_value,
        output busy, write_ack, reject
    );

endinterface

// File: rtl/guess_grid_ctrl_cursor_ctrl.sv
// cursor_ctrl: cursor position register with wrap-around on a 9x9 grid.
module cursor_ctrl
    import sudoku_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             move_en,
    input  dir_e             dir,
    output logic [POS_W-1:0] cursor_row,
    output logic [POS_W-1:0] cursor_col
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(GRID_DIM - 1);

    logic [POS_W-1:0] row_d;
    logic [POS_W-1:0] col_d;

    // Next position with wrap at both edges.
    always_comb begin
        row_d = cursor_row;
        col_d = cursor_col;
        if (move_en) begin
            case (dir)
                DIR_UP:    row_d = (cursor_row == '0)     ? POS_MAX : cursor_row - 4'd1;
                DIR_DOWN:  row_d = (cursor_row == POS_MAX) ? '0     : cursor_row + 4'd1;
                DIR_LEFT:  col_d = (cursor_col == '0)     ? POS_MAX : cursor_col - 4'd1;
                DIR_RIGHT: col_d = (cursor_col == POS_MAX) ? '0     : cursor_col + 4'd1;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cursor_row <= '0;
            cursor_col <= '0;
        end else begin
            cursor_row <= row_d;
            cursor_col <= col_d;
        end
    end

endmodule

// File: rtl/guess_grid_ctrl.sv
// guess_grid_ctrl: player guess grid storage, key command FSM and clear-all sweep.
// Optional LOCK_GIVENS_EN makes cells holding a puzzle given read-only.
module guess_grid_ctrl
    import sudoku_pkg::*;
#(
    parameter int unsigned CELLS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    guess_grid_ctrl_if.slave bus,
    input  grid_t            initial_grid,
    output grid_t            guess_grid,
    output logic [POS_W-1:0] cursor_row,
    output logic [POS_W-1:0] cursor_col
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [CELL_IDX_W-1:0] STEP     = CELL_IDX_W'(CELLS_PER_CYCLE);
    localparam logic [CELL_IDX_W-1:0] LAST_IDX = CELL_IDX_W'(NUM_CELLS - CELLS_PER_CYCLE);

    logic [0:0]            state_q, state_d;
    logic [CELL_IDX_W-1:0] idx_q, idx_d;
    grid_t                 grid_q, grid_d;
    logic                  ack_q, ack_d;
    logic                  rej_q, rej_d;
    logic                  busy_q;
    logic                  move_en;
    logic                  cell_wr;
    digit_t                wr_value;
    logic                  cur_given;

`ifdef LOCK_GIVENS_EN
    // A cell is locked when the puzzle supplies a given there.
    always_comb begin
        cur_given = 1'b0;
        for (int unsigned r = 0; r < GRID_DIM; r++) begin
            for (int unsigned c = 0; c < GRID_DIM; c++) begin
                if (POS_W'(r) == cursor_row && POS_W'(c) == cursor_col &&
                    initial_grid[r][c] != '0)
                    cur_given = 1'b1;
            end
        end
    end
`else
    logic unused_initial_grid;
    assign unused_initial_grid = ^initial_grid;
    assign cur_given           = 1'b0;
`endif

    cursor_ctrl u_cursor_ctrl (
        .clock      (clock),
        .reset_n    (reset_n),
        .move_en    (move_en),
        .dir        (dir_e'(bus.key_code[1:0])),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    // Next-state, grid update and result pulses.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        grid_d   = grid_q;
        ack_d    = 1'b0;
        rej_d    = 1'b0;
        move_en  = 1'b0;
        cell_wr  = 1'b0;
        wr_value = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.key_valid) begin
                    case (key_code_e'(bus.key_code))
                        KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT: move_en = 1'b1;
                        KEY_ENTER: begin
                            if (is_digit(bus.user_value) && !cur_given) begin
                                cell_wr  = 1'b1;
                                wr_value = bus.user_value;
                                ack_d    = 1'b1;
                            end else begin
                                rej_d = 1'b1;
                            end
                        end
                        KEY_ERASE: begin
                            if (!cur_given) begin
                                cell_wr = 1'b1;
                                ack_d   = 1'b1;
                            end else begin
                                rej_d = 1'b1;
                            end
                        end
                        KEY_CLEAR: begin
                            state_d = ST_CLEAR;
                            idx_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CLEAR: begin
                // Zero this cycle's row-major chunk, givens included.
                for (int unsigned r = 0; r < GRID_DIM; r++) begin
                    for (int unsigned c = 0; c < GRID_DIM; c++) begin
                        if (CELL_IDX_W'(r * GRID_DIM + c) >= idx_q &&
                            CELL_IDX_W'(r * GRID_DIM + c) < idx_q + STEP)
                            grid_d[r][c] = '0;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + STEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cell_wr) begin
            for (int unsigned r = 0; r < GRID_DIM; r++) begin
                for (int unsigned c = 0; c < GRID_DIM; c++) begin
                    if (POS_W'(r) == cursor_row && POS_W'(c) == cursor_col)
                        grid_d[r][c] = wr_value;
                end
            end
        end

        // Acknowledge the sweep during its last CLEAR cycle.
        if (state_d == ST_CLEAR && idx_d == LAST_IDX)
            ack_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            grid_q  <= '0;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grid_q  <= grid_d;
            ack_q   <= ack_d;
            rej_q   <= rej_d;
            busy_q  <= (state_d == ST_CLEAR);
        end
    end

    assign guess_grid    = grid_q;
    assign bus.busy      = busy_q;
    assign bus.write_ack = ack_q;
    assign bus.reject    = rej_q;

endmodule

// File: tb/tb_guess_grid_ctrl.sv
// Directed self-checking bench for guess_grid_ctrl (CELLS_PER_CYCLE = 1).
module tb_guess_grid_ctrl;
    import sudoku_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    grid_t      initial_grid;
    grid_t      guess_grid;
    logic [3:0] cursor_row;
    logic [3:0] cursor_col;
    int         checks = 0;
    int         errors = 0;

    guess_grid_ctrl_if bus ();

    guess_grid_ctrl #(.CELLS_PER_CYCLE(1)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .initial_grid (initial_grid),
        .guess_grid   (guess_grid),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One key strobe; returns at the negedge where its effects are visible.
    task automatic press(input logic [3:0] code, input logic [3:0] val);
        @(negedge clock);
        bus.key_valid  = 1'b1;
        bus.key_code   = code;
        bus.user_value = val;
        @(posedge clock);
        #1 bus.key_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = '0;
        bus.user_value = '0;
        initial_grid   = '0;
        initial_grid[0][0] = 4'd5;
        repeat (2) @(negedge clock);
        checks++; if (cursor_row !== 4'd0) begin errors++; $display("FAIL reset_row: got %0d expected 0", cursor_row); end
        checks++; if (cursor_col !== 4'd0) begin errors++; $display("FAIL reset_col: got %0d expected 0", cursor_col); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.write_ack !== 1'b0 || bus.reject !== 1'b0) begin errors++; $display("FAIL reset_pulses: got ack %b rej %b expected 0 0", bus.write_ack, bus.reject); end
        checks++; if (guess_grid !== '0) begin errors++; $display("FAIL reset_grid: got %h expected 0", guess_grid); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_cursor_wrap();
        press(KEY_UP, 4'd0);
        checks++; if (cursor_row !== 4'd8 || cursor_col !== 4'd0) begin errors++; $display("FAIL wrap_up: got (%0d,%0d) expected (8,0)", cursor_row, cursor_col); end
        checks++; if (bus.write_ack !== 1'b0 || bus.reject !== 1'b0) begin errors++; $display("FAIL move_no_pulse: got ack %b rej %b expected 0 0", bus.write_ack, bus.reject); end
        press(KEY_LEFT, 4'd0);
        checks++; if (cursor_row !== 4'd8 || cursor_col !== 4'd8) begin errors++; $display("FAIL wrap_left: got (%0d,%0d) expected (8,8)", cursor_row, cursor_col); end
        press(KEY_DOWN, 4'd0);
        checks++; if (cursor_row !== 4'd0 || cursor_col !== 4'd8) begin errors++; $display("FAIL wrap_down: got (%0d,%0d) expected (0,8)", cursor_row, cursor_col); end
        press(KEY_RIGHT, 4'd0);
        checks++; if (cursor_row !== 4'd0 || cursor_col !== 4'd0) begin errors++; $display("FAIL wrap_right: got (%0d,%0d) expected (0,0)", cursor_row, cursor_col); end
    endtask

    task automatic test_enter();
        repeat (4) press(KEY_DOWN, 4'd0);
        repeat (4) press(KEY_RIGHT, 4'd0);
        checks++; if (cursor_row !== 4'd4 || cursor_col !== 4'd4) begin errors++; $display("FAIL move_to_44: got (%0d,%0d) expected (4,4)", cursor_row, cursor_col); end
        press(KEY_ENTER, 4'd7);
        checks++; if (guess_grid[4][4] !== 4'd7) begin errors++; $display("FAIL enter_value: got %0d expected 7", guess_grid[4][4]); end
        checks++; if (bus.write_ack !== 1'b1 || bus.reject !== 1'b0) begin errors++; $display("FAIL enter_ack: got ack %b rej %b expected 1 0", bus.write_ack, bus.reject); end
        @(negedge clock);
        checks++; if (bus.write_ack !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b expected 0", bus.write_ack); end
        press(KEY_ENTER, 4'd0);
        checks++; if (bus.reject !== 1'b1 || bus.write_ack !== 1'b0) begin errors++; $display("FAIL enter_zero_rej: got ack %b rej %b expected 0 1", bus.write_ack, bus.reject); end
        checks++; if (guess_grid[4][4] !== 4'd7) begin errors++; $display("FAIL enter_zero_keep: got %0d expected 7", guess_grid[4][4]); end
        press(KEY_ENTER, 4'd10);
        checks++; if (bus.reject !== 1'b1 || bus.write_ack !== 1'b0) begin errors++; $display("FAIL enter_ten_rej: got ack %b rej %b expected 0 1", bus.write_ack, bus.reject); end
        checks++; if (guess_grid[4][4] !== 4'd7) begin errors++; $display("FAIL enter_ten_keep: got %0d expected 7", guess_grid[4][4]); end
        checks++; if (cursor_row !== 4'd4 || cursor_col !== 4'd4) begin errors++; $display("FAIL enter_cursor: got (%0d,%0d) expected (4,4)", cursor_row, cursor_col); end
    endtask

    task automatic test_erase_reserved();
        press(4'd9, 4'd3);
        checks++; if (bus.write_ack !== 1'b0 || bus.reject !== 1'b0) begin errors++; $display("FAIL reserved_pulse: got ack %b rej %b expected 0 0", bus.write_ack, bus.reject); end
        checks++; if (cursor_row !== 4'd4 || cursor_col !== 4'd4 || guess_grid[4][4] !== 4'd7) begin errors++; $display("FAIL reserved_state: got (%0d,%0d) cell %0d expected (4,4) cell 7", cursor_row, cursor_col, guess_grid[4][4]); end
        press(KEY_ERASE, 4'd0);
        checks++; if (bus.write_ack !== 1'b1 || guess_grid[4][4] !== 4'd0) begin errors++; $display("FAIL erase: got ack %b cell %0d expected 1 0", bus.write_ack, guess_grid[4][4]); end
        press(KEY_ENTER, 4'd7);
        checks++; if (guess_grid[4][4] !== 4'd7) begin errors++; $display("FAIL refill_44: got %0d expected 7", guess_grid[4][4]); end
    endtask

    task automatic test_givens();
        repeat (4) press(KEY_UP, 4'd0);
        repeat (4) press(KEY_LEFT, 4'd0);
        press(KEY_ENTER, 4'd3);
`ifdef LOCK_GIVENS_EN
        checks++; if (bus.reject !== 1'b1 || bus.write_ack !== 1'b0) begin errors++; $display("FAIL given_enter: got ack %b rej %b expected 0 1", bus.write_ack, bus.reject); end
        checks++; if (guess_grid[0][0] !== 4'd0) begin errors++; $display("FAIL given_cell: got %0d expected 0", guess_grid[0][0]); end
        press(KEY_ERASE, 4'd0);
        checks++; if (bus.reject !== 1'b1 || bus.write_ack !== 1'b0) begin errors++; $display("FAIL given_erase: got ack %b rej %b expected 0 1", bus.write_ack, bus.reject); end
`else
        checks++; if (bus.write_ack !== 1'b1 || bus.reject !== 1'b0) begin errors++; $display("FAIL given_enter: got ack %b rej %b expected 1 0", bus.write_ack, bus.reject); end
        checks++; if (guess_grid[0][0] !== 4'd3) begin errors++; $display("FAIL given_cell: got %0d expected 3", guess_grid[0][0]); end
`endif
        press(KEY_UP, 4'd0);
        press(KEY_LEFT, 4'd0);
        press(KEY_ENTER, 4'd9);
        checks++; if (bus.write_ack !== 1'b1 || guess_grid[8][8] !== 4'd9) begin errors++; $display("FAIL enter_88: got ack %b cell %0d expected 1 9", bus.write_ack, guess_grid[8][8]); end
    endtask

    task automatic test_clear_all();
        int busy_cycles = 0;
        int ack_cycle   = 0;
        int acks        = 0;
        int rejs        = 0;
        bit done        = 1'b0;
        press(KEY_CLEAR, 4'd0);
        for (int n = 0; n < 200 && !done; n++) begin
            if (n > 0) @(negedge clock);
            bus.key_valid = 1'b0;
            if (bus.busy === 1'b1) begin
                busy_cycles++;
                if (bus.write_ack === 1'b1) begin acks++; ack_cycle = busy_cycles; end
                if (bus.reject === 1'b1) rejs++;
                if (busy_cycles == 50) begin
                    checks++; if (guess_grid[4][4] !== 4'd0 || guess_grid[8][8] !== 4'd9) begin errors++; $display("FAIL sweep_order: got (4,4)=%0d (8,8)=%0d expected 0 9", guess_grid[4][4], guess_grid[8][8]); end
                end
                if (busy_cycles == 10) begin bus.key_valid = 1'b1; bus.key_code = KEY_DOWN; end
                if (busy_cycles == 20) begin bus.key_valid = 1'b1; bus.key_code = KEY_ENTER; bus.user_value = 4'd5; end
            end else begin
                done = 1'b1;
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clear_timeout: busy still %b after 200 cycles", bus.busy); end
        checks++; if (busy_cycles != 81) begin errors++; $display("FAIL clear_busy_len: got %0d expected 81", busy_cycles); end
        checks++; if (acks != 1 || ack_cycle != 81) begin errors++; $display("FAIL clear_ack: got %0d acks at cycle %0d expected 1 at 81", acks, ack_cycle); end
        checks++; if (rejs != 0) begin errors++; $display("FAIL clear_ignored_key: got %0d rejects expected 0", rejs); end
        checks++; if (guess_grid !== '0) begin errors++; $display("FAIL clear_grid: got %h expected 0", guess_grid); end
        checks++; if (cursor_row !== 4'd8 || cursor_col !== 4'd8) begin errors++; $display("FAIL clear_cursor: got (%0d,%0d) expected (8,8)", cursor_row, cursor_col); end
    endtask

    task automatic test_reset_mid_sweep();
        press(KEY_ENTER, 4'd1);
        checks++; if (guess_grid[8][8] !== 4'd1) begin errors++; $display("FAIL prefill_88: got %0d expected 1", guess_grid[8][8]); end
        press(KEY_CLEAR, 4'd0);
        repeat (39) @(negedge clock);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL sweep40_busy: got %b expected 1", bus.busy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.write_ack !== 1'b0 || bus.reject !== 1'b0) begin errors++; $display("FAIL async_rst_outs: got busy %b ack %b rej %b expected 0 0 0", bus.busy, bus.write_ack, bus.reject); end
        checks++; if (cursor_row !== 4'd0 || cursor_col !== 4'd0) begin errors++; $display("FAIL async_rst_cursor: got (%0d,%0d) expected (0,0)", cursor_row, cursor_col); end
        checks++; if (guess_grid !== '0) begin errors++; $display("FAIL async_rst_grid: got %h expected 0", guess_grid); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (bus.busy !== 1'b0 || bus.write_ack !== 1'b0) begin errors++; $display("FAIL no_resume: got busy %b ack %b expected 0 0", bus.busy, bus.write_ack); end
        press(KEY_RIGHT, 4'd0);
        press(KEY_ENTER, 4'd2);
        checks++; if (bus.write_ack !== 1'b1 || guess_grid[0][1] !== 4'd2) begin errors++; $display("FAIL post_reset_enter: got ack %b cell %0d expected 1 2", bus.write_ack, guess_grid[0][1]); end
    endtask

    initial begin
        test_reset();
        test_cursor_wrap();
        test_enter();
        test_erase_reserved();
        test_givens();
        test_clear_all();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
